// File: rtl/matrix_host.sv
// Host-side driver for the matrix engine nibble protocol: serializes one command
// as 23 nibbles, then collects the 9-word result burst onto a valid/ready port.
module matrix_host #(
  parameter int TIMEOUT = 64,
  parameter int GAP     = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         CMD_VALID,
  output logic         CMD_READY,
  input  logic [35:0]  CMD_A,
  input  logic [35:0]  CMD_B,
  input  logic [19:0]  CMD_NUM,
  output logic         IN_VALID,
  output logic [3:0]   IN,
  input  logic         OUT_VALID,
  input  logic [15:0]  OUT,
  output logic         RES_VALID,
  input  logic         RES_READY,
  output logic [143:0] RES,
  output logic         RES_ERR
);

  // state    | meaning
  // ST_IDLE  | ready for a command
  // ST_SEND  | shifting 23 nibbles onto IN
  // ST_WAIT  | waiting for the first OUT_VALID, timeout running
  // ST_RECV  | collecting the remaining result words
  // ST_DONE  | result presented, waiting for RES_READY
  // ST_HOLD  | idle gap before accepting the next command
  typedef enum logic [2:0] {
    ST_IDLE, ST_SEND, ST_WAIT, ST_RECV, ST_DONE, ST_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [91:0]   shreg_q, shreg_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [143:0]  res_d;
  logic          err_d;

  // One shared down-counter: nibbles left, timeout, words left, or gap cycles.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    res_d   = RES;
    err_d   = RES_ERR;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          shreg_d = {CMD_A, CMD_B, CMD_NUM};
          res_d   = '0;
          err_d   = 1'b0;
          cnt_d   = 16'd22;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        shreg_d = {shreg_q[87:0], 4'h0};
        if (cnt_q == 16'd0) begin
          cnt_d   = 16'(TIMEOUT - 1);
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_WAIT: begin
        if (OUT_VALID) begin
          res_d   = {RES[127:0], OUT};
          cnt_d   = 16'd8;
          state_d = ST_RECV;
        end else if (cnt_q == 16'd0) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_RECV: begin
        if (OUT_VALID) begin
          res_d = {RES[127:0], OUT};
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = ST_DONE;
        end else begin
          // Short burst: push the partial words up so the first word sits at the top.
          res_d   = RES << {cnt_q[3:0], 4'b0000};
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (RES_READY) begin
          if (GAP == 0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = 16'(GAP - 1);
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == 16'd0) state_d = ST_IDLE;
        else                cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so none depend combinationally on inputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      RES       <= '0;
      RES_ERR   <= 1'b0;
      CMD_READY <= 1'b1;
      IN_VALID  <= 1'b0;
      IN        <= 4'h0;
      RES_VALID <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      RES       <= res_d;
      RES_ERR   <= err_d;
      CMD_READY <= (state_d == ST_IDLE);
      IN_VALID  <= (state_d == ST_SEND);
      IN        <= (state_d == ST_SEND) ? shreg_d[91:88] : 4'h0;
      RES_VALID <= (state_d == ST_DONE);
    end
  end

endmodule
